// File: rtl/counter_4b.sv
// 4-bit synchronous up-counter with parallel load and synchronous clear.
// Priority per edge: reset clears, else load takes 'in', else count+1 (mod 16).
module counter_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] inc_sum;
  logic [WIDTH-1:0] carry;

  // Half-adder ripple chain adding a constant 1; the final carry is dropped so
  // 1111 wraps to 0000 with no flag.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inc
      assign inc_sum[gi] = count_reg[gi] ^ carry[gi];
      if (gi < WIDTH - 1) begin : g_carry
        assign carry[gi+1] = count_reg[gi] & carry[gi];
      end
    end
  endgenerate

  always_comb begin
    count_next = inc_sum;
    if (load) begin
      count_next = in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign out = count_reg;

endmodule

// File: tb/tb_counter_4b.sv
// Self-checking bench for counter_4b: directed literal checks plus randomized
// stimulus compared every cycle against an integer reference model.
module tb_counter_4b;

  logic       clk;
  logic       reset;
  logic [3:0] in;
  logic       load;
  logic [3:0] out;

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  bit model_valid = 1'b0;

  counter_4b #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic following the priority rules.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model_count = 0;
      model_valid = 1'b1;
    end else if (load === 1'b1) begin
      model_count = int'(in);
    end else begin
      model_count = (model_count + 1) % 16;
    end
  end

  // Every-cycle comparison, mid-cycle, once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (out !== 4'(model_count)) begin
        errors++;
        $display("FAIL model_cmp t=%0t out=%b expected=%b", $time, out, 4'(model_count));
      end
    end
  end

  task automatic drive(input logic r, input logic l, input logic [3:0] v);
    @(negedge clk);
    reset = r;
    load  = l;
    in    = v;
  endtask

  task automatic pin(input string name, input logic [3:0] want);
    @(posedge clk);
    #1;
    checks++;
    if (out !== want) begin
      errors++;
      $display("FAIL %s out=%b expected=%b", name, out, want);
    end else begin
      $display("check %s out=%b", name, out);
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    in    = 4'b0000;

    drive(1'b1, 1'b0, 4'b0000); pin("reset", 4'b0000);
    drive(1'b0, 1'b0, 4'b0000); pin("count1", 4'b0001);
    drive(1'b0, 1'b0, 4'b0000); pin("count2", 4'b0010);
    drive(1'b0, 1'b0, 4'b0101); pin("load_ignored", 4'b0011);
    drive(1'b0, 1'b1, 4'b0101); pin("load", 4'b0101);
    drive(1'b0, 1'b0, 4'b1100); pin("after_load", 4'b0110);
    drive(1'b1, 1'b1, 4'b1010); pin("reset_priority", 4'b0000);
    drive(1'b0, 1'b0, 4'b0000); pin("resume_from_zero", 4'b0001);
    drive(1'b0, 1'b1, 4'b1111); pin("load_max", 4'b1111);
    drive(1'b0, 1'b0, 4'b0000); pin("wrap0", 4'b0000);
    drive(1'b0, 1'b0, 4'b0000); pin("wrap1", 4'b0001);
    drive(1'b0, 1'b1, 4'b0000); pin("load_zero", 4'b0000);
    drive(1'b0, 1'b0, 4'b0111); pin("load_zero_next", 4'b0001);

    // Randomized phase: occasional reset, frequent loads, 'in' toggling freely.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      // Change 'in' mid-cycle when not loading; it must have no effect.
      if (!load) begin
        #2;
        in = 4'($urandom_range(0, 15));
      end
    end

    drive(1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
